// File: rtl/fifo_pkg.sv
// Shared byte-FIFO types and default sizes for the FIFO and its word packer.
package fifo_pkg;
  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PACK_DEF   = 4;

  typedef logic [FIFO_DW-1:0]          fifo_byte_t;
  typedef logic [PACK_DEF*FIFO_DW-1:0] packed_word_t;
endpackage

// File: rtl/fifo_word_out_reg.sv
// Valid/ready holding register for packed words; contents stay stable while stalled.
module fifo_word_out_reg
  import fifo_pkg::*;
#(
  parameter int PACK   = PACK_DEF,
  parameter int DATA_W = FIFO_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PACK*DATA_W-1:0] load_data,
  input  logic [PACK-1:0]        load_keep,
  input  logic                   load_last,
  output logic                   free,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PACK*DATA_W-1:0] m_data,
  output logic [PACK-1:0]        m_keep,
  output logic                   m_last
);
  // Free when empty or when the held word leaves on this edge.
  assign free = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO, packs bytes little-endian into PACK-byte words, closes partials on flush/timeout.
// Optional FIFO_WORD_PACKER_STATS_EN adds accepted-word and partial-word counters.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int PACK    = PACK_DEF,
  parameter int DATA_W  = FIFO_DW,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_pop,
  input  logic [DATA_W-1:0]      fifo_data_out,
  input  logic                   fifo_empty,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PACK*DATA_W-1:0] m_data,
  output logic [PACK-1:0]        m_keep,
  output logic                   m_last
`ifdef FIFO_WORD_PACKER_STATS_EN
  ,
  output logic [15:0]            word_cnt,
  output logic [15:0]            partial_cnt
`endif
);
  localparam int FW = $clog2(PACK + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FW:0]   PACK_OCC = (FW+1)'(PACK);
  localparam logic [IW-1:0] TO_MAX   = IW'(TIMEOUT);
  localparam logic [IW-1:0] TO_LAST  = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [PACK-1:0][DATA_W-1:0] lanes, load_lanes;
  logic [PACK-1:0]             load_keep;
  logic [FW-1:0]               fill_cnt;
  logic [FW:0]                 occ;
  logic [IW-1:0]               idle_cnt;
  logic pend, close_req, idle_cond, timeout_now, closing;
  logic full_word, close_word, out_free, xfer;

  assign occ       = {1'b0, fill_cnt} + (FW+1)'(pend);
  assign idle_cond = (fill_cnt != '0) && !pend && fifo_empty;
  // Fires on the idle cycle that brings idle_cnt to TIMEOUT, so the word leaves on that edge.
  assign timeout_now = (TIMEOUT > 0) && idle_cond && (idle_cnt >= TO_LAST);
  assign closing     = close_req || timeout_now;
  assign full_word   = (occ == PACK_OCC) && !pend;
  assign close_word  = closing && !pend && (fill_cnt != '0);
  assign xfer        = out_free && (full_word || close_word);
  assign fifo_pop    = !rst && !fifo_empty && (occ < PACK_OCC) && !close_req;

  // Unfilled lanes of a partial word go out as zero regardless of stale buffer contents.
  always_comb begin
    for (int i = 0; i < PACK; i++) begin
      load_keep[i]  = (FW'(i) < fill_cnt);
      load_lanes[i] = load_keep[i] ? lanes[i] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes     <= '0;
      fill_cnt  <= '0;
      pend      <= 1'b0;
      close_req <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      pend <= fifo_pop;
      for (int i = 0; i < PACK; i++)
        if (pend && fill_cnt == FW'(i)) lanes[i] <= fifo_data_out;
      if (pend)      fill_cnt <= fill_cnt + FW'(1);
      else if (xfer) fill_cnt <= '0;
      // A transfer empties the buffer, so a coincident flush has nothing left to close.
      if (xfer)                                      close_req <= 1'b0;
      else if ((flush && occ != '0) || timeout_now) close_req <= 1'b1;
      if (xfer || !idle_cond)      idle_cnt <= '0;
      else if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + IW'(1);
    end
  end

  fifo_word_out_reg #(.PACK(PACK), .DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (load_lanes),
    .load_keep (load_keep),
    .load_last (!full_word),
    .free      (out_free),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last)
  );

`ifdef FIFO_WORD_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= '0;
      partial_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (word_cnt != 16'hFFFF)              word_cnt    <= word_cnt + 16'd1;
      if (m_last && partial_cnt != 16'hFFFF) partial_cnt <= partial_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a registered byte-FIFO model and an accepted-word log.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  localparam int PACK = PACK_DEF;
  localparam int TMO  = 16;

  typedef struct packed {
    packed_word_t    d;
    logic [PACK-1:0] k;
    logic            l;
  } word_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fifo_pop;
  fifo_byte_t      fifo_data_out = '0;
  logic            fifo_empty = 1'b1;
  logic            flush = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  packed_word_t    m_data;
  logic [PACK-1:0] m_keep;
  logic            m_last;
`ifdef FIFO_WORD_PACKER_STATS_EN
  logic [15:0]     word_cnt, partial_cnt;
`endif

  int errors = 0, checks = 0, pop_cnt = 0, underflow = 0;
  fifo_byte_t fq[$];
  word_t      outq[$];

  always #5 clk = ~clk;

  fifo_word_packer #(.PACK(PACK), .DATA_W(FIFO_DW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_pop      (fifo_pop),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_keep        (m_keep),
    .m_last        (m_last)
`ifdef FIFO_WORD_PACKER_STATS_EN
    ,
    .word_cnt      (word_cnt),
    .partial_cnt   (partial_cnt)
`endif
  );

  // Byte FIFO model: read data and empty flag both registered, one cycle after the pop.
  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_cnt++;
      if (fq.size() > 0) fifo_data_out <= fq.pop_front();
      else underflow++;
    end
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk)
    if (!rst && m_valid && m_ready) outq.push_back({m_data, m_keep, m_last});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int c = 0;
    while (outq.size() < n && c < budget) begin tick(); c++; end
    ok = (outq.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fq.push_back(8'h5E);
    tick(); tick();
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data); end
    checks++; if (m_keep !== '0) begin errors++; $display("FAIL reset_keep got=%h exp=0", m_keep); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", m_last); end
    fq.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    fifo_byte_t sb[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    word_t exp0 = {32'h44332211, 4'hF, 1'b0};
    word_t exp1 = {32'h88776655, 4'hF, 1'b0};
    int n = 0, lat = 0;
    bit ok;
    m_ready = 1'b1;
    outq.delete();
    foreach (sb[i]) fq.push_back(sb[i]);
    while (!fifo_pop && n < 10) begin tick(); n++; end
    // Edges from the one sampling the first pop to the one registering m_valid.
    tick();
    while (!m_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat != PACK + 1) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", lat, PACK + 1); end
    wait_words(2, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_words got=%0d exp=2", outq.size()); end
    else begin
      if (outq[0] !== exp0) begin errors++; $display("FAIL stream_w0 got=%h exp=%h", outq[0], exp0); end
      checks++; if (outq[1] !== exp1) begin errors++; $display("FAIL stream_w1 got=%h exp=%h", outq[1], exp1); end
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    fifo_byte_t sb[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC};
    word_t exp[3] = '{{32'h44332211, 4'hF, 1'b0}, {32'h88776655, 4'hF, 1'b0},
                      {32'hCCBBAA99, 4'hF, 1'b0}};
    int c = 0, p0;
    bit ok, held_ok;
    m_ready = 1'b1;
    outq.delete();
    p0 = pop_cnt;
    foreach (sb[i]) fq.push_back(sb[i]);
    while (!m_valid && c < 30) begin tick(); c++; end
    m_ready = 1'b0;
    held_ok = m_valid;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m_valid || m_data !== 32'h44332211) held_ok = 1'b0;
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL bp_hold got=%h exp=44332211", m_data); end
    checks++; if (pop_cnt - p0 != 8) begin errors++; $display("FAIL bp_pops got=%0d exp=8", pop_cnt - p0); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_pop_stall got=%b exp=0", fifo_pop); end
    checks++; if (outq.size() != 0) begin errors++; $display("FAIL bp_no_accept got=%0d exp=0", outq.size()); end
    m_ready = 1'b1;
    wait_words(3, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_words got=%0d exp=3", outq.size()); end
    else
      for (int i = 0; i < 3; i++) begin
        if (i > 0) checks++;
        if (outq[i] !== exp[i]) begin errors++; $display("FAIL bp_w%0d got=%h exp=%h", i, outq[i], exp[i]); end
      end
    repeat (4) tick();
  endtask

  task automatic test_flush();
    word_t exp = {32'h00C3B2A1, 4'h7, 1'b1};
    bit ok;
    m_ready = 1'b1;
    outq.delete();
    fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
    repeat (8) tick();
    checks++; if (outq.size() != 0) begin errors++; $display("FAIL flush_early got=%0d exp=0", outq.size()); end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_words(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_word got=%0d exp=1", outq.size()); end
    else if (outq[0] !== exp) begin errors++; $display("FAIL flush_w0 got=%h exp=%h", outq[0], exp); end
    outq.delete();
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (25) tick();
    checks++;
    if (outq.size() != 0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty got=%0d words valid=%b exp=0", outq.size(), m_valid);
    end
  endtask

  task automatic test_timeout();
    word_t exp = {32'h0000A55A, 4'h3, 1'b1};
    int c = 0, n = 0;
    bit ok;
    m_ready = 1'b1;
    outq.delete();
    fq.push_back(8'h5A); fq.push_back(8'hA5);
    tick();
    while (!fifo_empty && c < 10) begin tick(); c++; end
    // One edge for the last popped byte to land, then TMO idle cycles.
    while (!m_valid && n < 40) begin tick(); n++; end
    checks++; if (n != TMO + 1) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", n, TMO + 1); end
    wait_words(1, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_word got=%0d exp=1", outq.size()); end
    else if (outq[0] !== exp) begin errors++; $display("FAIL timeout_w0 got=%h exp=%h", outq[0], exp); end
    repeat (4) tick();
  endtask

  task automatic test_flush_pend();
    word_t exp0 = {32'h00D3D2D1, 4'h7, 1'b1};
    word_t exp1 = {32'h000000D4, 4'h1, 1'b1};
    bit ok;
    m_ready = 1'b1;
    outq.delete();
    fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hD3); fq.push_back(8'hD4);
    tick(); tick(); tick();
    // Second byte in flight, third being popped this cycle.
    flush = 1'b1; tick(); flush = 1'b0;
    wait_words(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fpend_word got=%0d exp=1", outq.size()); end
    else if (outq[0] !== exp0) begin errors++; $display("FAIL fpend_w0 got=%h exp=%h", outq[0], exp0); end
    repeat (6) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_words(2, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fpend_single got=%0d exp=2", outq.size()); end
    else if (outq[1] !== exp1) begin errors++; $display("FAIL fpend_w1 got=%h exp=%h", outq[1], exp1); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    word_t exp = {32'hC4C3C2C1, 4'hF, 1'b0};
    bit ok;
    m_ready = 1'b1;
    outq.delete();
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
    repeat (4) tick();
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL rmid_pop_before got=%b exp=1", fifo_pop); end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_pop !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs got pop=%b v=%b d=%h k=%h l=%b exp=all 0", fifo_pop, m_valid, m_data, m_keep, m_last);
    end
    fq.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
    wait_words(1, 20, ok);
    repeat (24) tick();
    checks++;
    if (!ok || outq.size() != 1) begin errors++; $display("FAIL rmid_words got=%0d exp=1", outq.size()); end
    else if (outq[0] !== exp) begin errors++; $display("FAIL rmid_w0 got=%h exp=%h", outq[0], exp); end
  endtask

  task automatic test_fifo_protocol();
    checks++; if (underflow != 0) begin errors++; $display("FAIL pop_on_empty got=%0d exp=0", underflow); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_timeout();
    test_flush_pend();
    test_reset_mid();
    test_fifo_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
